// File: rtl/alu_op_sequencer.sv
// Multi-cycle control sequencer for the single-bus ALU datapath: fetch (T0-T2) and
// execute (T3-T6). T4 is stretched for the MUL/DIV units.
module alu_op_sequencer #(
  parameter int unsigned MULDIV_CYCLES = 32,
  parameter int unsigned OPW           = 5
) (
  input  logic           clock,
  input  logic           clear,
  input  logic           run,
  input  logic [OPW-1:0] ir_op,
  input  logic           mem_ready,
  output logic [15:0]    ctrl,
  output logic [3:0]     alu_op,
  output logic [1:0]     reg_sel,
  output logic           busy,
  output logic           halted,
  output logic           illegal
);

  typedef enum logic [3:0] {
    StIdle, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StHalt
  } state_t;

  localparam logic [7:0] CntLoad = 8'(MULDIV_CYCLES - 1);

  localparam int unsigned PcOut    = 0;
  localparam int unsigned MarIn    = 1;
  localparam int unsigned IncPc    = 2;
  localparam int unsigned ZIn      = 3;
  localparam int unsigned ZLowOut  = 4;
  localparam int unsigned PcIn     = 5;
  localparam int unsigned ReadB    = 6;
  localparam int unsigned MdrIn    = 7;
  localparam int unsigned MdrOut   = 8;
  localparam int unsigned IrIn     = 9;
  localparam int unsigned ROut     = 10;
  localparam int unsigned YIn      = 11;
  localparam int unsigned RIn      = 12;
  localparam int unsigned ZHighOut = 13;
  localparam int unsigned HiIn     = 14;
  localparam int unsigned LoIn     = 15;

  state_t         state_q;
  logic [7:0]     cnt_q;
  logic [OPW-1:0] op_q;
  logic           illegal_q;
  logic           op_muldiv;

  assign op_muldiv = (op_q == OPW'(6)) || (op_q == OPW'(7));

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q   <= StIdle;
      cnt_q     <= 8'd0;
      op_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= 1'b0;
      case (state_q)
        StIdle: if (run) state_q <= StT0;
        StT0:   state_q <= StT1;
        StT1:   if (mem_ready) state_q <= StT2;
        StT2:   state_q <= StT3;
        StT3: begin
          op_q <= ir_op;
          if (ir_op <= OPW'(12)) begin
            state_q <= StT4;
            cnt_q   <= CntLoad;
          end else if (ir_op == OPW'(31)) begin
            state_q <= StHalt;
          end else begin
            // Unused opcode executes as a NOP with a one-cycle flag.
            illegal_q <= 1'b1;
            state_q   <= run ? StT0 : StIdle;
          end
        end
        StT4: begin
          if (op_muldiv && (cnt_q != 8'd0)) cnt_q <= cnt_q - 8'd1;
          else                              state_q <= StT5;
        end
        StT5:   state_q <= op_muldiv ? StT6 : (run ? StT0 : StIdle);
        StT6:   state_q <= run ? StT0 : StIdle;
        StHalt: state_q <= StHalt;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Moore decode: depends only on registered state and latched opcode.
  always_comb begin
    ctrl    = 16'h0000;
    alu_op  = 4'h0;
    reg_sel = 2'd0;
    busy    = (state_q != StIdle) && (state_q != StHalt);
    halted  = (state_q == StHalt);
    illegal = illegal_q;
    case (state_q)
      StT0: begin
        ctrl[PcOut] = 1'b1;
        ctrl[MarIn] = 1'b1;
        ctrl[IncPc] = 1'b1;
        ctrl[ZIn]   = 1'b1;
        alu_op      = 4'hD;
      end
      StT1: begin
        ctrl[ZLowOut] = 1'b1;
        ctrl[PcIn]    = 1'b1;
        ctrl[ReadB]   = 1'b1;
        ctrl[MdrIn]   = 1'b1;
      end
      StT2: begin
        ctrl[MdrOut] = 1'b1;
        ctrl[IrIn]   = 1'b1;
      end
      StT3: begin
        ctrl[ROut] = 1'b1;
        ctrl[YIn]  = 1'b1;
        reg_sel    = 2'd1;
      end
      StT4: begin
        ctrl[ROut] = 1'b1;
        ctrl[ZIn]  = 1'b1;
        reg_sel    = 2'd2;
        alu_op     = op_q[3:0];
      end
      StT5: begin
        ctrl[ZLowOut] = 1'b1;
        if (op_muldiv) ctrl[LoIn] = 1'b1;
        else           ctrl[RIn]  = 1'b1;
      end
      StT6: begin
        ctrl[ZHighOut] = 1'b1;
        ctrl[HiIn]     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: a vector table for the main instruction flow
// plus hand-written HALT and asynchronous-clear sequences.
module tb_alu_op_sequencer;

  logic        clock = 1'b0;
  logic        clear;
  logic        run;
  logic [4:0]  ir_op;
  logic        mem_ready;
  logic [15:0] ctrl;
  logic [3:0]  alu_op;
  logic [1:0]  reg_sel;
  logic        busy;
  logic        halted;
  logic        illegal;

  int compared   = 0;
  int mismatched = 0;

  alu_op_sequencer #(
    .MULDIV_CYCLES(4),
    .OPW          (5)
  ) dut (
    .clock    (clock),
    .clear    (clear),
    .run      (run),
    .ir_op    (ir_op),
    .mem_ready(mem_ready),
    .ctrl     (ctrl),
    .alu_op   (alu_op),
    .reg_sel  (reg_sel),
    .busy     (busy),
    .halted   (halted),
    .illegal  (illegal)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        run;
    logic        mr;
    logic [4:0]  op;
    logic [15:0] ctrl;
    logic [3:0]  alu;
    logic [1:0]  sel;
    logic        busy;
    logic        halt;
    logic        ill;
  } vec_t;

  vec_t vecs[34];

  function automatic vec_t mk(logic r, logic m, logic [4:0] o, logic [15:0] c,
                              logic [3:0] a, logic [1:0] s, logic b, logic h, logic il);
    vec_t v;
    v.run = r;  v.mr = m;   v.op = o;   v.ctrl = c; v.alu = a;
    v.sel = s;  v.busy = b; v.halt = h; v.ill = il;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [15:0] c, input logic [3:0] a,
                         input logic [1:0] s, input logic b, input logic h, input logic il);
    chk({tag, " ctrl"},    ctrl,    c);
    chk({tag, " alu_op"},  {12'h0, alu_op},  {12'h0, a});
    chk({tag, " reg_sel"}, {14'h0, reg_sel}, {14'h0, s});
    chk({tag, " busy"},    {15'h0, busy},    {15'h0, b});
    chk({tag, " halted"},  {15'h0, halted},  {15'h0, h});
    chk({tag, " illegal"}, {15'h0, illegal}, {15'h0, il});
  endtask

  initial begin
    int n;
    // ADD (0x04), then MUL (0x06, 4 cycles), mem stall, illegal 0x0E, ROL with run dropped.
    vecs[0]  = mk(1, 1, 5'h04, 16'h0000, 4'h0, 2'd0, 0, 0, 0);
    vecs[1]  = mk(1, 1, 5'h04, 16'h000F, 4'hD, 2'd0, 1, 0, 0);
    vecs[2]  = mk(1, 1, 5'h04, 16'h00F0, 4'h0, 2'd0, 1, 0, 0);
    vecs[3]  = mk(1, 1, 5'h04, 16'h0300, 4'h0, 2'd0, 1, 0, 0);
    vecs[4]  = mk(1, 1, 5'h04, 16'h0C00, 4'h0, 2'd1, 1, 0, 0);
    vecs[5]  = mk(1, 1, 5'h1F, 16'h0408, 4'h4, 2'd2, 1, 0, 0);
    vecs[6]  = mk(1, 1, 5'h1F, 16'h1010, 4'h0, 2'd0, 1, 0, 0);
    vecs[7]  = mk(1, 1, 5'h06, 16'h000F, 4'hD, 2'd0, 1, 0, 0);
    vecs[8]  = mk(1, 1, 5'h06, 16'h00F0, 4'h0, 2'd0, 1, 0, 0);
    vecs[9]  = mk(1, 1, 5'h06, 16'h0300, 4'h0, 2'd0, 1, 0, 0);
    vecs[10] = mk(1, 1, 5'h06, 16'h0C00, 4'h0, 2'd1, 1, 0, 0);
    vecs[11] = mk(1, 1, 5'h00, 16'h0408, 4'h6, 2'd2, 1, 0, 0);
    vecs[12] = mk(1, 1, 5'h00, 16'h0408, 4'h6, 2'd2, 1, 0, 0);
    vecs[13] = mk(1, 1, 5'h00, 16'h0408, 4'h6, 2'd2, 1, 0, 0);
    vecs[14] = mk(1, 1, 5'h00, 16'h0408, 4'h6, 2'd2, 1, 0, 0);
    vecs[15] = mk(1, 1, 5'h00, 16'h8010, 4'h0, 2'd0, 1, 0, 0);
    vecs[16] = mk(0, 1, 5'h00, 16'h6000, 4'h0, 2'd0, 1, 0, 0);
    vecs[17] = mk(0, 1, 5'h00, 16'h0000, 4'h0, 2'd0, 0, 0, 0);
    vecs[18] = mk(1, 1, 5'h00, 16'h0000, 4'h0, 2'd0, 0, 0, 0);
    vecs[19] = mk(1, 0, 5'h00, 16'h000F, 4'hD, 2'd0, 1, 0, 0);
    vecs[20] = mk(1, 0, 5'h00, 16'h00F0, 4'h0, 2'd0, 1, 0, 0);
    vecs[21] = mk(1, 0, 5'h00, 16'h00F0, 4'h0, 2'd0, 1, 0, 0);
    vecs[22] = mk(1, 0, 5'h00, 16'h00F0, 4'h0, 2'd0, 1, 0, 0);
    vecs[23] = mk(1, 1, 5'h00, 16'h00F0, 4'h0, 2'd0, 1, 0, 0);
    vecs[24] = mk(1, 1, 5'h0E, 16'h0300, 4'h0, 2'd0, 1, 0, 0);
    vecs[25] = mk(1, 1, 5'h0E, 16'h0C00, 4'h0, 2'd1, 1, 0, 0);
    vecs[26] = mk(1, 1, 5'h0C, 16'h000F, 4'hD, 2'd0, 1, 0, 1);
    vecs[27] = mk(1, 1, 5'h0C, 16'h00F0, 4'h0, 2'd0, 1, 0, 0);
    vecs[28] = mk(0, 1, 5'h0C, 16'h0300, 4'h0, 2'd0, 1, 0, 0);
    vecs[29] = mk(0, 1, 5'h0C, 16'h0C00, 4'h0, 2'd1, 1, 0, 0);
    vecs[30] = mk(0, 1, 5'h0C, 16'h0408, 4'hC, 2'd2, 1, 0, 0);
    vecs[31] = mk(0, 1, 5'h0C, 16'h1010, 4'h0, 2'd0, 1, 0, 0);
    vecs[32] = mk(0, 1, 5'h0C, 16'h0000, 4'h0, 2'd0, 0, 0, 0);
    vecs[33] = mk(0, 1, 5'h0C, 16'h0000, 4'h0, 2'd0, 0, 0, 0);

    clear = 1'b1; run = 1'b1; ir_op = 5'h04; mem_ready = 1'b1;
    step();
    step();
    chk_all("reset", 16'h0000, 4'h0, 2'd0, 0, 0, 0);
    clear = 1'b0;

    for (int i = 0; i < 34; i++) begin
      run       = vecs[i].run;
      mem_ready = vecs[i].mr;
      ir_op     = vecs[i].op;
      chk_all($sformatf("v%0d", i), vecs[i].ctrl, vecs[i].alu, vecs[i].sel,
              vecs[i].busy, vecs[i].halt, vecs[i].ill);
      step();
    end

    // HALT: IDLE -> T0..T3 -> HALT in 5 edges, bounded wait.
    run = 1'b1; ir_op = 5'h1F; mem_ready = 1'b1;
    n = 0;
    for (int k = 0; k < 20 && !halted; k++) begin
      step();
      n++;
    end
    chk("halt cycles", 16'(n), 16'd5);
    chk_all("halt", 16'h0000, 4'h0, 2'd0, 0, 1, 0);
    for (int k = 0; k < 4; k++) begin
      run = ~run;
      step();
      chk("halt held", {15'h0, halted}, 16'h0001);
    end
    clear = 1'b1;
    #1;
    chk_all("halt clear", 16'h0000, 4'h0, 2'd0, 0, 0, 0);
    step();
    clear = 1'b0;

    // Illegal 0x0E, then MUL cut by an asynchronous clear in T4.
    run = 1'b1; ir_op = 5'h0E;
    for (int k = 0; k < 4; k++) step();
    chk("nop T3 ctrl", ctrl, 16'h0C00);
    step();
    ir_op = 5'h06;
    chk("ill pulse", {15'h0, illegal}, 16'h0001);
    chk("ill to T0", ctrl, 16'h000F);
    step();
    chk("ill one cycle", {15'h0, illegal}, 16'h0000);
    step();
    step();
    step();
    chk("mul T4 ctrl", ctrl, 16'h0408);
    chk("mul T4 alu", {12'h0, alu_op}, 16'h0006);
    #3;
    clear = 1'b1;
    #1;
    chk_all("async clear", 16'h0000, 4'h0, 2'd0, 0, 0, 0);
    step();
    clear = 1'b0;
    chk_all("post clear", 16'h0000, 4'h0, 2'd0, 0, 0, 0);
    step();
    chk("restart T0", ctrl, 16'h000F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
